spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter LEN_DATA, default 8, frame width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on SCLK/SS/MOSI.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 SCLK  input  1  serial clock from master; high pulse >= 1 clk period, low time >= SYNC_STAGES+1 clk periods.
REQ-006 SS  input  1  slave select, active-low.
REQ-007 MOSI  input  1  serial data in, MSB first.
REQ-008 MISO  output  1  serial data out, MSB first.
REQ-009 tx_data  input  LEN_DATA  next byte to transmit.
REQ-010 tx_load  input  1  one-cycle strobe writing tx_data into the staging register.
REQ-011 tx_ready  output  1  staging register empty; tx_load is accepted.
REQ-012 rx_data  output  LEN_DATA  last complete received byte; held until the next byte completes.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-014 frame_err  output  1  one-cycle pulse when SS rises mid-byte.
REQ-015 busy  output  1  high while the state is not IDLE.

Function
REQ-016 SCLK, SS and MOSI each pass through SYNC_STAGES flops; edges are detected on the synchronized values.
REQ-017 Mode: MOSI sampled on the SCLK rising edge; MISO advances on the SCLK falling edge.
REQ-018 FSM states: IDLE, SHIFT, DONE.
REQ-019 IDLE -> SHIFT on synchronized SS falling edge; at that cycle the shift-out register loads the staging byte (or 0xFF if staging is empty), MISO presents its MSB, and tx_ready goes high.
REQ-020 SHIFT: each rising edge shifts MOSI into the LSB of rx_shift and increments a bit counter of width clog2(LEN_DATA); the counter wraps at LEN_DATA-1 -> 0.
REQ-021 SHIFT: each falling edge shifts the tx register left; MISO equals its MSB.
REQ-022 On the rising edge where the counter wraps: SHIFT -> DONE; rx_data <= rx_shift including the new bit; rx_valid pulses.
REQ-023 rx_valid latency is exactly SYNC_STAGES+1 clk cycles after the 8th SCLK rising edge at the pin.
REQ-024 DONE -> SHIFT on the next cycle if SS is still low, reloading the tx register from staging (0xFF if empty) so multi-byte frames are back-to-back.
REQ-025 DONE -> IDLE if SS is high.
REQ-026 In SHIFT, an SS rising edge with counter != 0: pulse frame_err, discard the partial byte (no rx_valid), clear the counter, go to IDLE.
REQ-027 An SS rising edge in the same cycle as the completing rising edge is not an error: rx_valid pulses and the state then goes to IDLE.
REQ-028 tx_load while tx_ready=1: staging <= tx_data; tx_ready <= 0 on the next cycle.
REQ-029 tx_load while tx_ready=0 is ignored; the staging content is unchanged.
REQ-030 tx_load in the same cycle as a staging consume: the consume takes the old content and the new tx_data is stored; tx_ready stays 0.
REQ-031 MISO = 0 whenever the state is IDLE.
REQ-032 SCLK edges while SS is high are ignored.

Reset
REQ-033 rst asynchronously forces: state IDLE, counter 0, rx_shift/rx_data 0, rx_valid 0, frame_err 0, MISO 0, busy 0, tx_ready 1, staging 0, synchronizer flops to idle levels (SCLK 0, SS 1, MOSI 0).
REQ-034 Reset asserted mid-frame abandons the frame without rx_valid or frame_err; after release the block waits for a fresh SS falling edge.

Structure
REQ-035 LEN_DATA, the FSM state encodings and the 0xFF idle pattern belong in a shared SPI package, together with the master's constants.
REQ-036 One sub-module, spi_sync, holds the SYNC_STAGES-deep synchronizer plus rise/fall edge detect; it is instantiated for SCLK and SS, and a plain synchronizer is used for MOSI.

Verification
REQ-037 tx_load 0x3C, then an 8-bit frame with MOSI=0xA5 -> rx_data=0xA5 with a single rx_valid pulse 3 clk after the 8th rise; master captures MISO=0x3C.
REQ-038 No tx_load, a 2-byte frame with MOSI 0x01,0x80 -> rx_valid twice (0x01, 0x80); MISO=0xFF,0xFF.
REQ-039 SS rises after 5 bits -> frame_err=1 for exactly one clk, no rx_valid, rx_data keeps its prior value, busy=0.
REQ-040 tx_load 0x11 then tx_load 0x22 while tx_ready=0 -> the frame transmits 0x11; 0x22 is dropped.
REQ-041 rst pulse after 4 bits, then a full frame MOSI=0x5A -> rx_data=0x5A, no frame_err, all outputs at reset values during rst.
REQ-042 SCLK toggles with SS high -> no counter change, MISO=0, no rx_valid.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI constants: frame width, slave FSM encodings, idle fill pattern
// and the timing constants used by the matching SPI master.
package spi_pkg;

    localparam int LEN_DATA    = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Shifted out whenever the host has not supplied a byte in time.
    localparam logic [LEN_DATA-1:0] IDLE_PATTERN = 8'hFF;

    localparam int   MASTER_CLK_DIV = 8;
    localparam logic MASTER_CPOL    = 1'b0;
    localparam logic MASTER_CPHA    = 1'b0;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall strobes derived from the synchronized level.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: MOSI captured on SCLK rise, MISO advanced on SCLK fall,
// single-byte staging register on the transmit side.
module spi_slave
    import spi_pkg::*;
#(
    parameter int LEN_DATA    = spi_pkg::LEN_DATA,
    parameter int SYNC_STAGES = spi_pkg::SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                SS,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [LEN_DATA-1:0] tx_data,
    input  logic                tx_load,
    output logic                tx_ready,
    output logic [LEN_DATA-1:0] rx_data,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                busy
);

    localparam int CW = (LEN_DATA > 1) ? $clog2(LEN_DATA) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(LEN_DATA - 1);
    // The idle pattern is all-ones, so it is widened by replication.
    localparam logic [LEN_DATA-1:0] FILL = {LEN_DATA{IDLE_PATTERN[0]}};

    logic sclkRise, sclkFall;
    logic ssSync, ssRise, ssFall;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic mosiBit;

    logic [1:0]          state_q,   state_d;
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic [LEN_DATA-1:0] rxShift_q, rxShift_d;
    logic [LEN_DATA-1:0] rxData_q,  rxData_d;
    logic                rxValid_q, rxValid_d;
    logic                frameErr_q, frameErr_d;
    logic [LEN_DATA-1:0] txShift_q, txShift_d;
    logic [LEN_DATA-1:0] staging_q, staging_d;
    logic                txReady_q, txReady_d;

    logic                consume;
    logic                lastRise;
    logic [LEN_DATA-1:0] rxNext;
    logic [LEN_DATA-1:0] stageOut;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSclkSync (
        .clk(clk), .rst(rst), .async_i(SCLK),
        .sync_o(), .rise_o(sclkRise), .fall_o(sclkFall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSsSync (
        .clk(clk), .rst(rst), .async_i(SS),
        .sync_o(ssSync), .rise_o(ssRise), .fall_o(ssFall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosiSync_q <= '0;
        end else begin
            mosiSync_q[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosiSync_q[i] <= mosiSync_q[i-1];
            end
        end
    end

    assign mosiBit  = mosiSync_q[SYNC_STAGES-1];
    assign rxNext   = {rxShift_q[LEN_DATA-2:0], mosiBit};
    assign stageOut = txReady_q ? FILL : staging_q;
    assign lastRise = sclkRise && (cnt_q == LAST_BIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rxShift_d  = rxShift_q;
        rxData_d   = rxData_q;
        rxValid_d  = 1'b0;
        frameErr_d = 1'b0;
        txShift_d  = txShift_q;
        consume    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ssFall) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    consume   = 1'b1;
                    txShift_d = stageOut;
                end
            end
            ST_SHIFT: begin
                // The fall right after the last rise belongs to the finished
                // byte; gating on a nonzero count keeps it off the reloaded byte.
                if (sclkRise) begin
                    rxShift_d = rxNext;
                    if (lastRise) begin
                        cnt_d     = '0;
                        rxData_d  = rxNext;
                        rxValid_d = 1'b1;
                        state_d   = ssRise ? ST_IDLE : ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclkFall && (cnt_q != '0)) begin
                    txShift_d = txShift_q << 1;
                end
                if (ssRise && !lastRise) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    frameErr_d = (cnt_q != '0);
                end
            end
            ST_DONE: begin
                if (ssSync) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_SHIFT;
                    consume   = 1'b1;
                    txShift_d = stageOut;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        staging_d = staging_q;
        txReady_d = txReady_q;
        if (tx_load && (txReady_q || consume)) begin
            staging_d = tx_data;
            txReady_d = 1'b0;
        end else if (consume) begin
            txReady_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rxShift_q  <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            frameErr_q <= 1'b0;
            txShift_q  <= '0;
            staging_q  <= '0;
            txReady_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rxShift_q  <= rxShift_d;
            rxData_q   <= rxData_d;
            rxValid_q  <= rxValid_d;
            frameErr_q <= frameErr_d;
            txShift_q  <= txShift_d;
            staging_q  <= staging_d;
            txReady_q  <= txReady_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign MISO      = busy & txShift_q[LEN_DATA-1];
    assign rx_data   = rxData_q;
    assign rx_valid  = rxValid_q;
    assign frame_err = frameErr_q;
    assign tx_ready  = txReady_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master feeds directed bytes while a
// negedge monitor matches every rx_valid against a queue of expected bytes.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       SS = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int errPulses   = 0;
    int errHigh     = 0;
    logic errPrev   = 1'b0;

    logic [7:0] expData[$];
    int         expCyc[$];

    spi_slave #(.LEN_DATA(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops an expected byte and cycle for every rx_valid sample
    always @(negedge clk) begin
        if (frame_err) begin
            errHigh++;
            if (!errPrev) errPulses++;
        end
        errPrev = frame_err;
        if (rx_valid) begin
            if (expData.size() == 0) begin
                checkOutput("unexpected rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                checkOutput("rx_data", 32'(rx_data), 32'(expData.pop_front()));
                checkOutput("rx_valid latency", 32'(cyc), 32'(expCyc.pop_front()));
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        waitClk(1);
        tx_load = 1'b0;
    endtask

    // Master clocks nBits bits MSB first, sampling MISO just before each rise
    task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits,
                                 input bit expectRx, output logic [7:0] misoByte);
        misoByte = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            MOSI = mosiByte[7-i];
            waitClk(3);
            misoByte = {misoByte[6:0], MISO};
            SCLK = 1'b1;
            if (i == 7 && expectRx) begin
                expData.push_back(mosiByte);
                expCyc.push_back(cyc + 3);
            end
            waitClk(4);
            SCLK = 1'b0;
            waitClk(6);
        end
    endtask

    logic [7:0] miso;
    int         errBase;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, nCompared=%0d", nCompared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitClk(2);
        checkOutput("reset MISO", 32'(MISO), 32'h0);
        checkOutput("reset tx_ready", 32'(tx_ready), 32'h1);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset rx_data", 32'(rx_data), 32'h0);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        waitClk(4);

        $display("[TB] single byte with staged 0x3C");
        loadByte(8'h3C);
        checkOutput("tx_ready after load", 32'(tx_ready), 32'h0);
        SS = 1'b0; waitClk(6);
        checkOutput("busy in frame", 32'(busy), 32'h1);
        checkOutput("tx_ready after consume", 32'(tx_ready), 32'h1);
        applyStimulus(8'hA5, 8, 1'b1, miso);
        checkOutput("MISO byte 0x3C", 32'(miso), 32'h3C);
        SS = 1'b1; waitClk(6);
        checkOutput("busy after frame", 32'(busy), 32'h0);

        $display("[TB] two-byte frame, nothing staged");
        SS = 1'b0; waitClk(6);
        applyStimulus(8'h01, 8, 1'b1, miso);
        checkOutput("MISO fill byte 1", 32'(miso), 32'hFF);
        applyStimulus(8'h80, 8, 1'b1, miso);
        checkOutput("MISO fill byte 2", 32'(miso), 32'hFF);
        SS = 1'b1; waitClk(6);
        checkOutput("rx_data after 2 bytes", 32'(rx_data), 32'h80);

        $display("[TB] SS rises after 5 bits");
        errBase = errPulses;
        SS = 1'b0; waitClk(6);
        applyStimulus(8'hF0, 5, 1'b0, miso);
        SS = 1'b1; waitClk(6);
        checkOutput("frame_err pulses", 32'(errPulses - errBase), 32'h1);
        checkOutput("frame_err width", 32'(errHigh - errBase), 32'h1);
        checkOutput("rx_data held", 32'(rx_data), 32'h80);
        checkOutput("busy after abort", 32'(busy), 32'h0);

        $display("[TB] second load while staging full is dropped");
        loadByte(8'h11);
        loadByte(8'h22);
        checkOutput("tx_ready full", 32'(tx_ready), 32'h0);
        SS = 1'b0; waitClk(6);
        applyStimulus(8'h00, 8, 1'b1, miso);
        checkOutput("MISO keeps 0x11", 32'(miso), 32'h11);
        SS = 1'b1; waitClk(6);

        $display("[TB] reset mid-frame, then full frame");
        errBase = errPulses;
        SS = 1'b0; waitClk(6);
        applyStimulus(8'hFF, 4, 1'b0, miso);
        rst = 1'b1;
        SS = 1'b1;
        waitClk(2);
        checkOutput("mid rst MISO", 32'(MISO), 32'h0);
        checkOutput("mid rst busy", 32'(busy), 32'h0);
        checkOutput("mid rst tx_ready", 32'(tx_ready), 32'h1);
        checkOutput("mid rst rx_data", 32'(rx_data), 32'h0);
        checkOutput("mid rst rx_valid", 32'(rx_valid), 32'h0);
        checkOutput("mid rst frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0; waitClk(6);
        SS = 1'b0; waitClk(6);
        applyStimulus(8'h5A, 8, 1'b1, miso);
        SS = 1'b1; waitClk(6);
        checkOutput("rx_data after rst", 32'(rx_data), 32'h5A);
        checkOutput("no frame_err on rst", 32'(errPulses - errBase), 32'h0);

        $display("[TB] SCLK toggles with SS high");
        MOSI = 1'b1;
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1; waitClk(4);
            SCLK = 1'b0; waitClk(6);
            checkOutput("MISO idle", 32'(MISO), 32'h0);
            checkOutput("busy idle", 32'(busy), 32'h0);
        end
        SS = 1'b0; waitClk(6);
        applyStimulus(8'hC3, 8, 1'b1, miso);
        SS = 1'b1; waitClk(6);

        $display("[TB] load coinciding with staging consume");
        loadByte(8'h77);
        SS = 1'b0; waitClk(2);
        tx_data = 8'h99;
        tx_load = 1'b1;
        waitClk(1);
        tx_load = 1'b0;
        checkOutput("tx_ready after load+consume", 32'(tx_ready), 32'h0);
        waitClk(6);
        applyStimulus(8'hE7, 8, 1'b1, miso);
        checkOutput("MISO old staging", 32'(miso), 32'h77);
        applyStimulus(8'h18, 8, 1'b1, miso);
        checkOutput("MISO new staging", 32'(miso), 32'h99);
        SS = 1'b1; waitClk(6);
        checkOutput("tx_ready drained", 32'(tx_ready), 32'h1);

        waitClk(10);
        checkOutput("pending rx bytes", 32'(expData.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
